// File: rtl/dma_dreq_agent_if.sv
// DREQ/DACK bus between the request agent and the 8237-style DMA, plus per-channel control and status.
// The master side is the agent (drives DREQ and status); the slave side is the DMA/host stimulus.
interface dma_dreq_agent_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0]       start;
  logic [2*NUM_CH-1:0]     mode;
  logic [CNT_W*NUM_CH-1:0] count;
  logic [NUM_CH-1:0]       DACK;
  logic                    xfer_stb;
  logic                    EOP_n;

  logic [NUM_CH-1:0]       DREQ;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH-1:0]       err;
  logic [NUM_CH-1:0]       eop_seen;
  logic [CNT_W*NUM_CH-1:0] xfer_cnt;

  modport master (
    input  start, mode, count, DACK, xfer_stb, EOP_n,
    output DREQ, busy, done, err, eop_seen, xfer_cnt
  );

  modport slave (
    output start, mode, count, DACK, xfer_stb, EOP_n,
    input  DREQ, busy, done, err, eop_seen, xfer_cnt
  );
endinterface

// File: rtl/dma_dreq_agent.sv
// Multi-channel DREQ agent: independent per-channel single/block/demand sequencers ending on count, EOP_n or watchdog.
// Outputs registered, 1 cycle after the sampled cause; the DMA paces us purely through DACK/xfer_stb.
module dma_dreq_agent #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 16,
  parameter int WD_W           = 24,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic              CLK,
  input logic              RESET,
  dma_dreq_agent_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ACT,
    S_DRAIN,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [1:0]      M_SINGLE = 2'b00;
  localparam logic [1:0]      M_RSVD   = 2'b11;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           r_state, w_state_nxt;
    logic [1:0]       r_mode, w_mode_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [CNT_W:0]   r_cnt, w_cnt_nxt;
    logic [WD_W-1:0]  r_wd, w_wd_nxt;
    logic             r_dreq, w_dreq_nxt;
    logic             r_err, w_err_nxt;
    logic             r_eop, w_eop_nxt;
    logic             r_done;

    logic             w_dack;
    logic             w_cred;
    logic [CNT_W:0]   w_tgt;
    logic [CNT_W:0]   w_cnt_inc;
    logic             w_last;
    logic             w_timeout;
    logic [WD_W-1:0]  w_wd_step;

    // Counter is one bit wider so count=all-ones still reaches its target of 2**CNT_W.
    assign w_dack    = bus.DACK[g];
    assign w_cred    = bus.xfer_stb & w_dack;
    assign w_tgt     = {1'b0, r_count} + (CNT_W+1)'(1);
    assign w_cnt_inc = r_cnt + (CNT_W+1)'(w_cred && (r_cnt != w_tgt));
    assign w_last    = (w_cnt_inc == w_tgt);
    assign w_timeout = !w_cred && (r_wd == WD_LIMIT);
    assign w_wd_step = w_cred ? '0 : r_wd + WD_W'(1);

    always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_count_nxt = r_count;
      w_cnt_nxt   = r_cnt;
      w_wd_nxt    = r_wd;
      w_dreq_nxt  = r_dreq;
      w_err_nxt   = r_err;
      w_eop_nxt   = r_eop;

      unique case (r_state)
        S_IDLE: begin
          w_dreq_nxt = 1'b0;
          if (bus.start[g]) begin
            w_mode_nxt  = bus.mode[2*g +: 2];
            w_count_nxt = bus.count[CNT_W*g +: CNT_W];
            w_cnt_nxt   = '0;
            w_wd_nxt    = '0;
            w_eop_nxt   = 1'b0;
            if (bus.mode[2*g +: 2] == M_RSVD) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_DONE;
            end else begin
              w_err_nxt   = 1'b0;
              w_dreq_nxt  = 1'b1;
              w_state_nxt = S_REQ;
            end
          end
        end

        S_REQ: begin
          w_wd_nxt = w_wd_step;
          if (w_timeout) begin
            w_err_nxt   = 1'b1;
            w_dreq_nxt  = 1'b0;
            w_state_nxt = S_DONE;
          end else if (w_dack) begin
            w_state_nxt = S_ACT;
          end
        end

        S_ACT: begin
          w_wd_nxt  = w_wd_step;
          w_cnt_nxt = w_cnt_inc;
          if (w_timeout) begin
            w_err_nxt   = 1'b1;
            w_dreq_nxt  = 1'b0;
            w_state_nxt = S_DONE;
          end else if (!w_dack) begin
            // The last transfer always leaves via DRAIN, so a DACK fall here is mid-sequence.
            w_dreq_nxt  = (r_mode != M_SINGLE);
            w_state_nxt = (r_mode == M_SINGLE) ? S_GAP : S_REQ;
          end else if (!bus.EOP_n) begin
            w_eop_nxt   = 1'b1;
            w_dreq_nxt  = 1'b0;
            w_state_nxt = S_DRAIN;
          end else if (w_last) begin
            w_dreq_nxt  = 1'b0;
            w_state_nxt = S_DRAIN;
          end else begin
            unique case (r_mode)
              2'b00:   w_dreq_nxt = r_dreq & ~w_cred;
              2'b01:   w_dreq_nxt = 1'b0;
              default: w_dreq_nxt = 1'b1;
            endcase
          end
        end

        S_DRAIN: begin
          w_wd_nxt   = w_wd_step;
          w_dreq_nxt = 1'b0;
          if (w_timeout) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else if (!w_dack) begin
            w_state_nxt = S_DONE;
          end
        end

        S_GAP: begin
          w_dreq_nxt  = 1'b1;
          w_state_nxt = S_REQ;
        end

        S_DONE: begin
          w_dreq_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end

        default: begin
          w_dreq_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        r_state <= S_IDLE;
        r_mode  <= '0;
        r_count <= '0;
        r_cnt   <= '0;
        r_wd    <= '0;
        r_dreq  <= 1'b0;
        r_err   <= 1'b0;
        r_eop   <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_mode  <= w_mode_nxt;
        r_count <= w_count_nxt;
        r_cnt   <= w_cnt_nxt;
        r_wd    <= w_wd_nxt;
        r_dreq  <= w_dreq_nxt;
        r_err   <= w_err_nxt;
        r_eop   <= w_eop_nxt;
        r_done  <= (w_state_nxt == S_DONE);
      end
    end

    assign bus.DREQ[g]                       = r_dreq;
    assign bus.busy[g]                       = (r_state != S_IDLE);
    assign bus.done[g]                       = r_done;
    assign bus.err[g]                        = r_err;
    assign bus.eop_seen[g]                   = r_eop;
    assign bus.xfer_cnt[CNT_W*g +: CNT_W]    = r_cnt[CNT_W-1:0];
  end

endmodule

// File: tb/tb_dma_dreq_agent.sv
// Scoreboard bench for dma_dreq_agent: expected sequence results are queued at start and checked on done.
module tb_dma_dreq_agent;
  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  dma_dreq_agent_if #(.NUM_CH(4), .CNT_W(8)) bus ();

  dma_dreq_agent #(
    .NUM_CH(4), .CNT_W(8), .WD_W(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  typedef struct {
    int         ch;
    logic [7:0] cnt;
    logic       err;
    logic       eop;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  int         dreq_rise[4] = '{default: 0};
  int         done_seen[4] = '{default: 0};
  logic [3:0] dreq_q = '0;

  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.DREQ[i] && !dreq_q[i]) dreq_rise[i] <= dreq_rise[i] + 1;
      if (bus.done[i]) done_seen[i] <= done_seen[i] + 1;
    end
    dreq_q <= bus.DREQ;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_ch(input int ch, input logic [1:0] m, input logic [7:0] c);
    bus.mode[2*ch +: 2]  = m;
    bus.count[8*ch +: 8] = c;
    bus.start[ch]        = 1'b1;
    tick();
    bus.start[ch]        = 1'b0;
  endtask

  task automatic wait_done(input int ch, output bit seen);
    int n = 0;
    while (bus.done[ch] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    seen = (bus.done[ch] === 1'b1);
  endtask

  task automatic test_reset();
    bus.start = '0; bus.mode = '0; bus.count = '0; bus.DACK = '0;
    bus.xfer_stb = 1'b0; bus.EOP_n = 1'b1;
    RESET = 1'b1;
    tick(); tick();
    total++;
    if ({bus.DREQ, bus.busy, bus.done, bus.err, bus.eop_seen} !== 20'h0) begin
      bad++;
      $display("FAIL reset_flags: got %h want 0", {bus.DREQ, bus.busy, bus.done, bus.err, bus.eop_seen});
    end
    total++;
    if (bus.xfer_cnt !== 32'h0) begin
      bad++;
      $display("FAIL reset_cnt: got %h want 0", bus.xfer_cnt);
    end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_single();
    exp_t e;
    bit   seen;
    int   rise0 = dreq_rise[0];
    sb.push_back('{ch: 0, cnt: 8'd3, err: 1'b0, eop: 1'b0});
    start_ch(0, 2'b00, 8'd2);
    for (int k = 0; k < 3; k++) begin
      bus.DACK[0] = 1'b1; tick();
      bus.xfer_stb = 1'b1; tick();
      bus.xfer_stb = 1'b0;
      total++;
      if (bus.DREQ[0] !== 1'b0) begin
        bad++; $display("FAIL single_drop%0d: DREQ=%b want 0", k, bus.DREQ[0]);
      end
      bus.DACK[0] = 1'b0;
      if (k < 2) begin
        tick();
        total++;
        if (bus.DREQ[0] !== 1'b0) begin
          bad++; $display("FAIL single_gap%0d: DREQ=%b want 0", k, bus.DREQ[0]);
        end
        tick();
        total++;
        if (bus.DREQ[0] !== 1'b1) begin
          bad++; $display("FAIL single_rereq%0d: DREQ=%b want 1", k, bus.DREQ[0]);
        end
      end
    end
    wait_done(0, seen);
    e = sb.pop_front();
    total++;
    if (!seen || bus.xfer_cnt[8*e.ch +: 8] !== e.cnt || bus.err[e.ch] !== e.err || bus.eop_seen[e.ch] !== e.eop) begin
      bad++;
      $display("FAIL single_result: done=%b cnt=%0d err=%b eop=%b want done=1 cnt=%0d err=%b eop=%b",
               seen, bus.xfer_cnt[8*e.ch +: 8], bus.err[e.ch], bus.eop_seen[e.ch], e.cnt, e.err, e.eop);
    end
    tick();
    total++;
    if (dreq_rise[0] - rise0 !== 3 || bus.busy[0] !== 1'b0 || bus.done[0] !== 1'b0) begin
      bad++;
      $display("FAIL single_pulses: rises=%0d busy=%b done=%b want 3 0 0", dreq_rise[0] - rise0, bus.busy[0], bus.done[0]);
    end
  endtask

  task automatic test_block();
    exp_t e;
    bit   seen;
    sb.push_back('{ch: 1, cnt: 8'd4, err: 1'b0, eop: 1'b0});
    start_ch(1, 2'b01, 8'd3);
    bus.DACK[1] = 1'b1; tick();
    total++;
    if (bus.DREQ[1] !== 1'b1) begin
      bad++; $display("FAIL block_hold: DREQ=%b want 1", bus.DREQ[1]);
    end
    tick();
    total++;
    if (bus.DREQ[1] !== 1'b0) begin
      bad++; $display("FAIL block_drop: DREQ=%b want 0", bus.DREQ[1]);
    end
    bus.xfer_stb = 1'b1;
    repeat (4) tick();
    bus.xfer_stb = 1'b0;
    total++;
    if (bus.xfer_cnt[15:8] !== 8'd4 || bus.done[1] !== 1'b0 || bus.busy[1] !== 1'b1) begin
      bad++;
      $display("FAIL block_drain: cnt=%0d done=%b busy=%b want 4 0 1", bus.xfer_cnt[15:8], bus.done[1], bus.busy[1]);
    end
    bus.xfer_stb = 1'b1; tick();
    bus.xfer_stb = 1'b0;
    total++;
    if (bus.xfer_cnt[15:8] !== 8'd4) begin
      bad++; $display("FAIL block_extra_stb: cnt=%0d want 4", bus.xfer_cnt[15:8]);
    end
    bus.DACK[1] = 1'b0;
    wait_done(1, seen);
    e = sb.pop_front();
    total++;
    if (!seen || bus.xfer_cnt[8*e.ch +: 8] !== e.cnt || bus.err[e.ch] !== e.err || bus.eop_seen[e.ch] !== e.eop) begin
      bad++;
      $display("FAIL block_result: done=%b cnt=%0d err=%b eop=%b want done=1 cnt=%0d err=%b eop=%b",
               seen, bus.xfer_cnt[8*e.ch +: 8], bus.err[e.ch], bus.eop_seen[e.ch], e.cnt, e.err, e.eop);
    end
    tick();
  endtask

  task automatic test_demand();
    exp_t e;
    bit   seen;
    sb.push_back('{ch: 2, cnt: 8'd6, err: 1'b0, eop: 1'b0});
    start_ch(2, 2'b10, 8'd5);
    bus.DACK[2] = 1'b1; tick();
    bus.xfer_stb = 1'b1; tick(); tick();
    bus.xfer_stb = 1'b0;
    start_ch(2, 2'b01, 8'd0);
    total++;
    if (bus.DREQ[2] !== 1'b1 || bus.xfer_cnt[23:16] !== 8'd2) begin
      bad++; $display("FAIL demand_mid: DREQ=%b cnt=%0d want 1 2", bus.DREQ[2], bus.xfer_cnt[23:16]);
    end
    bus.DACK[2] = 1'b0; tick();
    total++;
    if (bus.DREQ[2] !== 1'b1) begin
      bad++; $display("FAIL demand_rereq: DREQ=%b want 1", bus.DREQ[2]);
    end
    bus.DACK[2] = 1'b1; tick();
    bus.xfer_stb = 1'b1;
    repeat (4) tick();
    bus.xfer_stb = 1'b0;
    total++;
    if (bus.DREQ[2] !== 1'b0) begin
      bad++; $display("FAIL demand_last: DREQ=%b want 0", bus.DREQ[2]);
    end
    bus.DACK[2] = 1'b0;
    wait_done(2, seen);
    e = sb.pop_front();
    total++;
    if (!seen || bus.xfer_cnt[8*e.ch +: 8] !== e.cnt || bus.err[e.ch] !== e.err || bus.eop_seen[e.ch] !== e.eop) begin
      bad++;
      $display("FAIL demand_result: done=%b cnt=%0d err=%b eop=%b want done=1 cnt=%0d err=%b eop=%b",
               seen, bus.xfer_cnt[8*e.ch +: 8], bus.err[e.ch], bus.eop_seen[e.ch], e.cnt, e.err, e.eop);
    end
    tick();
  endtask

  task automatic test_eop();
    exp_t e;
    bit   seen;
    sb.push_back('{ch: 3, cnt: 8'd2, err: 1'b0, eop: 1'b1});
    start_ch(3, 2'b00, 8'd9);
    bus.DACK[3] = 1'b1; tick();
    bus.xfer_stb = 1'b1; tick();
    bus.xfer_stb = 1'b0; bus.DACK[3] = 1'b0; tick();
    tick();
    bus.DACK[3] = 1'b1; tick();
    bus.xfer_stb = 1'b1; bus.EOP_n = 1'b0; tick();
    bus.xfer_stb = 1'b0; bus.EOP_n = 1'b1;
    total++;
    if (bus.DREQ[3] !== 1'b0 || bus.eop_seen[3] !== 1'b1) begin
      bad++; $display("FAIL eop_flag: DREQ=%b eop=%b want 0 1", bus.DREQ[3], bus.eop_seen[3]);
    end
    bus.DACK[3] = 1'b0;
    wait_done(3, seen);
    e = sb.pop_front();
    total++;
    if (!seen || bus.xfer_cnt[8*e.ch +: 8] !== e.cnt || bus.err[e.ch] !== e.err || bus.eop_seen[e.ch] !== e.eop
        || bus.DREQ[3] !== 1'b0) begin
      bad++;
      $display("FAIL eop_result: done=%b cnt=%0d err=%b eop=%b DREQ=%b want done=1 cnt=%0d err=%b eop=%b DREQ=0",
               seen, bus.xfer_cnt[8*e.ch +: 8], bus.err[e.ch], bus.eop_seen[e.ch], bus.DREQ[3], e.cnt, e.err, e.eop);
    end
    tick();
  endtask

  task automatic test_timeout();
    exp_t e;
    bit   seen;
    sb.push_back('{ch: 0, cnt: 8'd0, err: 1'b1, eop: 1'b0});
    start_ch(0, 2'b00, 8'd0);
    repeat (15) tick();
    total++;
    if (bus.DREQ[0] !== 1'b1 || bus.err[0] !== 1'b0) begin
      bad++; $display("FAIL timeout_early: DREQ=%b err=%b want 1 0", bus.DREQ[0], bus.err[0]);
    end
    tick();
    seen = (bus.done[0] === 1'b1);
    e = sb.pop_front();
    total++;
    if (!seen || bus.DREQ[0] !== 1'b0 || bus.xfer_cnt[8*e.ch +: 8] !== e.cnt || bus.err[e.ch] !== e.err
        || bus.eop_seen[e.ch] !== e.eop) begin
      bad++;
      $display("FAIL timeout_at16: done=%b DREQ=%b cnt=%0d err=%b eop=%b want done=1 DREQ=0 cnt=%0d err=%b eop=%b",
               seen, bus.DREQ[0], bus.xfer_cnt[8*e.ch +: 8], bus.err[e.ch], bus.eop_seen[e.ch], e.cnt, e.err, e.eop);
    end
    tick();
    sb.push_back('{ch: 0, cnt: 8'd1, err: 1'b0, eop: 1'b0});
    start_ch(0, 2'b00, 8'd0);
    total++;
    if (bus.err[0] !== 1'b0 || bus.DREQ[0] !== 1'b1) begin
      bad++; $display("FAIL timeout_restart: err=%b DREQ=%b want 0 1", bus.err[0], bus.DREQ[0]);
    end
    bus.DACK[0] = 1'b1; tick();
    bus.xfer_stb = 1'b1; tick();
    bus.xfer_stb = 1'b0; bus.DACK[0] = 1'b0;
    wait_done(0, seen);
    e = sb.pop_front();
    total++;
    if (!seen || bus.xfer_cnt[8*e.ch +: 8] !== e.cnt || bus.err[e.ch] !== e.err || bus.eop_seen[e.ch] !== e.eop) begin
      bad++;
      $display("FAIL count0_result: done=%b cnt=%0d err=%b eop=%b want done=1 cnt=%0d err=%b eop=%b",
               seen, bus.xfer_cnt[8*e.ch +: 8], bus.err[e.ch], bus.eop_seen[e.ch], e.cnt, e.err, e.eop);
    end
    tick();
  endtask

  task automatic test_reserved();
    exp_t e;
    bit   seen;
    sb.push_back('{ch: 1, cnt: 8'd0, err: 1'b1, eop: 1'b0});
    start_ch(1, 2'b11, 8'd4);
    wait_done(1, seen);
    e = sb.pop_front();
    total++;
    if (!seen || bus.DREQ[1] !== 1'b0 || bus.xfer_cnt[8*e.ch +: 8] !== e.cnt || bus.err[e.ch] !== e.err
        || bus.eop_seen[e.ch] !== e.eop) begin
      bad++;
      $display("FAIL reserved_result: done=%b DREQ=%b cnt=%0d err=%b want done=1 DREQ=0 cnt=%0d err=%b",
               seen, bus.DREQ[1], bus.xfer_cnt[8*e.ch +: 8], bus.err[e.ch], e.cnt, e.err);
    end
    tick();
  endtask

  task automatic test_reset_multi();
    int d0, d2;
    bus.mode[1:0] = 2'b00; bus.count[7:0]   = 8'd3;
    bus.mode[5:4] = 2'b10; bus.count[23:16] = 8'd3;
    bus.start = 4'b0101; tick();
    bus.start = 4'b0000;
    bus.DACK = 4'b0101; tick();
    bus.xfer_stb = 1'b1; tick();
    bus.xfer_stb = 1'b0;
    total++;
    if (bus.xfer_cnt[7:0] !== 8'd1 || bus.xfer_cnt[23:16] !== 8'd1 || bus.DREQ !== 4'b0100) begin
      bad++;
      $display("FAIL multi_credit: cnt0=%0d cnt2=%0d DREQ=%b want 1 1 0100", bus.xfer_cnt[7:0], bus.xfer_cnt[23:16], bus.DREQ);
    end
    d0 = done_seen[0]; d2 = done_seen[2];
    RESET = 1'b1; tick();
    total++;
    if ({bus.DREQ, bus.busy, bus.done, bus.err, bus.eop_seen} !== 20'h0 || bus.xfer_cnt !== 32'h0) begin
      bad++;
      $display("FAIL multi_reset: flags=%h cnt=%h want 0 0", {bus.DREQ, bus.busy, bus.done, bus.err, bus.eop_seen}, bus.xfer_cnt);
    end
    tick();
    RESET = 1'b0; bus.DACK = 4'b0000;
    repeat (3) tick();
    total++;
    if (done_seen[0] !== d0 || done_seen[2] !== d2 || bus.busy !== 4'b0000) begin
      bad++;
      $display("FAIL multi_no_done: done0=%0d done2=%0d busy=%b want %0d %0d 0000", done_seen[0], done_seen[2], bus.busy, d0, d2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_block();
    test_demand();
    test_eop();
    test_timeout();
    test_reserved();
    test_reset_multi();
    total++;
    if (sb.size() !== 0) begin
      bad++; $display("FAIL scoreboard_drain: left=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "bench timeout");
  end

endmodule
